// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate engine.
// Mode codes, FSM state encoding and the effective-amount helper.
package shift_pkg;

    localparam logic [2:0] SHR  = 3'd0;
    localparam logic [2:0] SHRA = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] ROR  = 3'd3;
    localparam logic [2:0] ROL  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // sat: the full amount is >= width; low: amount mod width.
    // Shifts saturate at width, rotates wrap, reserved codes do nothing.
    function automatic int unsigned eff_amount(
        input logic [2:0]  mode,
        input logic        sat,
        input int unsigned low,
        input int unsigned width
    );
        int unsigned eff;
        eff = 0;
        unique case (1'b1)
            (mode == ROR) || (mode == ROL):
                eff = low;
            (mode == SHR) || (mode == SHRA) || (mode == SHL):
                eff = sat ? width : low;
            default:
                eff = 0;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bits.
// Ports: data/k/mode/fill in; result (shifted data), last (final bit out).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  logic [2:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    logic             rot;
    logic             left;
    logic [2*WIDTH:0] right_in;
    logic [2*WIDTH:0] left_in;
    logic [WIDTH:0]   right_lo;
    logic [WIDTH:0]   left_hi;

    // A guard bit below (right) or above (left) the data catches the
    // last bit moved out; it stays 0 when k is 0.
    always_comb begin
        rot      = (mode == ROR) || (mode == ROL);
        left     = (mode == SHL) || (mode == ROL);
        right_in = {(rot ? data : {WIDTH{fill}}), data, 1'b0};
        left_in  = {1'b0, data, (rot ? data : {WIDTH{1'b0}})};
        right_lo = (WIDTH + 1)'(right_in >> k);
        left_hi  = (WIDTH + 1)'((left_in << k) >> WIDTH);
        result   = right_lo[WIDTH:1];
        last     = right_lo[0];
        if (left) begin
            result = left_hi[WIDTH-1:0];
            last   = left_hi[WIDTH];
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate engine (SHR, SHRA, SHL, ROR, ROL), STEP bits/cycle.
// Ports: clk, clr (sync reset), start, mode, operand, amount in;
// result, busy, done out; zero_flag, carry_out when SHIFT_FLAGS_EN is defined.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             carry_out
`endif
);

    localparam int KW = $clog2(STEP + 1);
    localparam int RW = AMT_W + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] result_d;
    logic             busy_d, done_d;

    logic             sat;
    logic [RW-1:0]    cap_eff;
    logic [2:0]       cap_mode;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_out;
    logic             step_last;

    always_comb begin
        sat      = |amount[WIDTH-1:AMT_W];
        cap_eff  = RW'(eff_amount(mode, sat,
                        32'(amount[AMT_W-1:0]), WIDTH));
        // Reserved codes run as SHR; their eff is already 0.
        cap_mode = (mode <= ROL) ? mode : SHR;
        k        = (rem_q >= RW'(STEP)) ? KW'(STEP) : rem_q[KW-1:0];
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data   (work_q),
        .k      (k),
        .mode   (mode_q),
        .fill   (fill_q),
        .result (step_out),
        .last   (step_last)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        result_d = result;
        busy_d   = busy;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = operand;
                    rem_d   = cap_eff;
                    mode_d  = cap_mode;
                    fill_d  = (mode == SHRA) & operand[WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    result_d = work_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    work_d = step_out;
                    rem_d  = rem_q - RW'(k);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= SHR;
            fill_q  <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            result  <= result_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

`ifdef SHIFT_FLAGS_EN
    // carry_q tracks the last bit moved out; cleared at capture so
    // an eff of 0 reports no carry.
    logic carry_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            carry_q   <= 1'b0;
            zero_flag <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                carry_q <= 1'b0;
            end else if (state_q == RUN && rem_q != '0) begin
                carry_q <= step_last;
            end
            if (state_q == RUN && rem_q == '0) begin
                zero_flag <= (work_q == '0);
                carry_out <= carry_q;
            end
        end
    end
`else
    logic unused_step_last;
    assign unused_step_last = step_last;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit (STEP=1 and STEP=4 instances).
// Expected results come from a bit-serial model via a scoreboard queue.
module tb_iter_shift_unit;

    localparam int W     = 32;
    localparam int BOUND = 100;

    localparam logic [2:0] M_SHR  = 3'd0;
    localparam logic [2:0] M_SHRA = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_ROR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         start1 = 1'b0;
    logic         start4 = 1'b0;
    logic [2:0]   mode = '0;
    logic [W-1:0] operand = '0;
    logic [W-1:0] amount = '0;

    logic [W-1:0] res1, res4;
    logic         busy1, busy4, done1, done4;
`ifdef SHIFT_FLAGS_EN
    logic         zf1, zf4, co1, co4;
`endif

    always #5 clk = ~clk;

    iter_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
        .clk       (clk),
        .clr       (clr),
        .start     (start1),
        .mode      (mode),
        .operand   (operand),
        .amount    (amount),
        .result    (res1),
        .busy      (busy1),
        .done      (done1)
`ifdef SHIFT_FLAGS_EN
        ,
        .zero_flag (zf1),
        .carry_out (co1)
`endif
    );

    iter_shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk       (clk),
        .clr       (clr),
        .start     (start4),
        .mode      (mode),
        .operand   (operand),
        .amount    (amount),
        .result    (res4),
        .busy      (busy4),
        .done      (done4)
`ifdef SHIFT_FLAGS_EN
        ,
        .zero_flag (zf4),
        .carry_out (co4)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sel4 = 1'b0;

    logic [W-1:0] o_res;
    logic         o_busy, o_done;
    assign o_res  = sel4 ? res4 : res1;
    assign o_busy = sel4 ? busy4 : busy1;
    assign o_done = sel4 ? done4 : done1;
`ifdef SHIFT_FLAGS_EN
    logic o_zf, o_co;
    assign o_zf = sel4 ? zf4 : zf1;
    assign o_co = sel4 ? co4 : co1;
`endif

    // Reference: apply eff single-bit operations one at a time.
    function automatic void model(
        input  logic [2:0]   m,
        input  logic [W-1:0] op,
        input  logic [W-1:0] amt,
        input  int           step,
        output logic [W-1:0] r,
        output logic         c,
        output int           lat
    );
        int e;
        r = op;
        c = 1'b0;
        e = 0;
        if (m == M_ROR || m == M_ROL) e = int'(amt % 32);
        else if (m <= M_SHL) e = (amt >= 32) ? 32 : int'(amt);
        for (int i = 0; i < e; i++) begin
            case (m)
                M_SHR:  begin c = r[0];  r = {1'b0, r[W-1:1]}; end
                M_SHRA: begin c = r[0];  r = {op[W-1], r[W-1:1]}; end
                M_SHL:  begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
                M_ROR:  begin c = r[0];  r = {r[0], r[W-1:1]}; end
                default: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
            endcase
        end
        lat = (e + step - 1) / step + 1;
    endfunction

    // Push the expectation, then present start for one edge (edge N).
    task automatic launch(input logic [2:0] m, input logic [W-1:0] op,
                          input logic [W-1:0] amt, input string name);
        exp_t e;
        model(m, op, amt, sel4 ? 4 : 1, e.res, e.carry, e.lat);
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        mode    = m;
        operand = op;
        amount  = amt;
        if (sel4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Bounded wait for done; cyc counts edges after the call point.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < BOUND) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clr    = 1'b1;
        start1 = 1'b1;
        mode   = M_SHL;
        amount = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (res1 !== '0) begin
            n_bad++; $display("FAIL reset_res1 got %h want 0", res1);
        end
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy1 got %b want 0", busy1);
        end
        n_cmp++;
        if (done1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_done1 got %b want 0", done1);
        end
        n_cmp++;
        if (res4 !== '0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dut4 got %h/%b/%b want 0/0/0",
                     res4, busy4, done4);
        end
`ifdef SHIFT_FLAGS_EN
        n_cmp++;
        if (zf1 !== 1'b0 || co1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got %b%b want 00", zf1, co1);
        end
`endif
        @(negedge clk);
        start1 = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic test_shra_timing();
        int   cyc;
        exp_t e;
        sel4 = 1'b0;
        launch(M_SHRA, 32'h8000_0004, 32'd2, "shra_timing");
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_bad++; $display("FAIL shra_busy got %b want 1", o_busy);
        end
        wait_done(cyc);
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.lat || cyc !== 3) begin
            n_bad++; $display("FAIL shra_latency got %0d want 3", cyc);
        end
        n_cmp++;
        if (o_res !== 32'hE000_0001) begin
            n_bad++; $display("FAIL shra_result got %h want e0000001", o_res);
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("FAIL shra_busy_done got %b want 0", o_busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_done !== 1'b0) begin
            n_bad++; $display("FAIL shra_done_pulse got %b want 0", o_done);
        end
        n_cmp++;
        if (o_res !== 32'hE000_0001) begin
            n_bad++; $display("FAIL shra_hold got %h want e0000001", o_res);
        end
    endtask

    // One table-driven op: compare result, latency and flags.
    task automatic test_ops(input bit use4);
        logic [2:0]   tm [10];
        logic [W-1:0] top[10];
        logic [W-1:0] tam[10];
        tm[0] = M_SHR;  top[0] = 32'h8000_0004; tam[0] = 32'd2;
        tm[1] = M_SHL;  top[1] = 32'h0000_0003; tam[1] = 32'd1;
        tm[2] = M_ROL;  top[2] = 32'h8000_0001; tam[2] = 32'd4;
        tm[3] = M_ROR;  top[3] = 32'h8000_0001; tam[3] = 32'd36;
        tm[4] = M_SHL;  top[4] = 32'hFFFF_FFFF; tam[4] = 32'd40;
        tm[5] = M_SHRA; top[5] = 32'h8000_0000; tam[5] = 32'd100;
        tm[6] = 3'd6;   top[6] = 32'hDEAD_BEEF; tam[6] = 32'd7;
        tm[7] = M_SHR;  top[7] = 32'h1234_5678; tam[7] = 32'd0;
        tm[8] = M_ROL;  top[8] = 32'hA5A5_0001; tam[8] = 32'd32;
        tm[9] = M_SHR;  top[9] = 32'hF000_0000; tam[9] = 32'd10;
        sel4 = use4;
        for (int i = 0; i < 10; i++) begin
            int   cyc;
            exp_t e;
            launch(tm[i], top[i], tam[i], "op");
            wait_done(cyc);
            e = sb.pop_front();
            n_cmp++;
            if (o_res !== e.res) begin
                n_bad++;
                $display("FAIL op%0d_s%0d_result got %h want %h",
                         i, use4 ? 4 : 1, o_res, e.res);
            end
            n_cmp++;
            if (cyc !== e.lat) begin
                n_bad++;
                $display("FAIL op%0d_s%0d_latency got %0d want %0d",
                         i, use4 ? 4 : 1, cyc, e.lat);
            end
`ifdef SHIFT_FLAGS_EN
            n_cmp++;
            if (o_co !== e.carry || o_zf !== (e.res == '0)) begin
                n_bad++;
                $display("FAIL op%0d_flags got c%b z%b want c%b z%b",
                         i, o_co, o_zf, e.carry, (e.res == '0));
            end
`endif
        end
    endtask

    task automatic test_step4();
        int   cyc;
        exp_t e;
        sel4 = 1'b1;
        launch(M_SHR, 32'hF000_0000, 32'd10, "step4");
        wait_done(cyc);
        e = sb.pop_front();
        n_cmp++;
        if (o_res !== 32'h003C_0000) begin
            n_bad++; $display("FAIL step4_result got %h want 003c0000", o_res);
        end
        n_cmp++;
        if (cyc !== 4) begin
            n_bad++; $display("FAIL step4_latency got %0d want 4", cyc);
        end
    endtask

`ifdef SHIFT_FLAGS_EN
    task automatic test_flags();
        int cyc;
        sel4 = 1'b0;
        launch(M_SHR, 32'h0000_0003, 32'd1, "flags");
        wait_done(cyc);
        void'(sb.pop_front());
        n_cmp++;
        if (o_co !== 1'b1 || o_zf !== 1'b0) begin
            n_bad++; $display("FAIL flags_shr got c%b z%b want c1 z0", o_co, o_zf);
        end
    endtask
`endif

    task automatic test_busy_ignore();
        int   cyc;
        exp_t e;
        sel4 = 1'b0;
        launch(M_SHR, 32'h1234_5678, 32'd8, "busy_ignore");
        @(negedge clk);
        start1  = 1'b1;
        operand = 32'hFFFF_FFFF;
        mode    = M_ROL;
        amount  = 32'd3;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(cyc);
        e = sb.pop_front();
        n_cmp++;
        if (o_res !== e.res) begin
            n_bad++; $display("FAIL busy_ignore_result got %h want %h", o_res, e.res);
        end
        n_cmp++;
        if (cyc + 1 !== e.lat) begin
            n_bad++; $display("FAIL busy_ignore_latency got %0d want %0d", cyc + 1, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        sel4 = 1'b0;
        launch(M_ROL, 32'h0000_00F1, 32'd3, "b2b_a");
        wait_done(cyc);
        e = sb.pop_front();
        n_cmp++;
        if (o_res !== e.res) begin
            n_bad++; $display("FAIL b2b_a_result got %h want %h", o_res, e.res);
        end
        launch(M_SHRA, 32'h9000_0000, 32'd5, "b2b_b");
        n_cmp++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept got busy%b done%b want busy1 done0",
                              o_busy, o_done);
        end
        wait_done(cyc);
        e = sb.pop_front();
        n_cmp++;
        if (o_res !== e.res || cyc !== e.lat) begin
            n_bad++; $display("FAIL b2b_b got %h/%0d want %h/%0d",
                              o_res, cyc, e.res, e.lat);
        end
    endtask

    task automatic test_clr_mid();
        int ndone;
        sel4 = 1'b0;
        launch(M_SHL, 32'h0000_FFFF, 32'd20, "clr_mid");
        void'(sb.pop_front());
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_res !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL clr_mid got %h/%b/%b want 0/0/0",
                              o_res, o_busy, o_done);
        end
        @(negedge clk);
        clr   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++; $display("FAIL clr_mid_no_done got %0d pulses want 0", ndone);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int           cyc;
            exp_t         e;
            logic [2:0]   m;
            logic [W-1:0] op, amt;
            sel4 = i[0];
            m    = 3'($urandom_range(0, 7));
            op   = $urandom;
            amt  = (i % 4 == 3) ? $urandom : 32'($urandom_range(0, 70));
            launch(m, op, amt, "rand");
            wait_done(cyc);
            e = sb.pop_front();
            n_cmp++;
            if (o_res !== e.res || cyc !== e.lat) begin
                n_bad++;
                $display("FAIL rand%0d m%0d op %h amt %h got %h/%0d want %h/%0d",
                         i, m, op, amt, o_res, cyc, e.res, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shra_timing();
        test_ops(1'b0);
        test_ops(1'b1);
        test_step4();
`ifdef SHIFT_FLAGS_EN
        test_flags();
`endif
        test_busy_ignore();
        test_back_to_back();
        test_clr_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
